// File: rtl/fetch_pkg.sv
// Shared types, default geometry and the bird opacity rule for the pixel fetch scheduler.
package fetch_pkg;

    typedef enum logic [1:0] {
        BG   = 2'd0,
        PIPE = 2'd1,
        BIRD = 2'd2
    } layer_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        CHK  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Default sprite placement and ROM packing
    localparam int BIRD_X_DEF    = 300;
    localparam int BIRD_W_DEF    = 40;
    localparam int BIRD_H_DEF    = 40;
    localparam int PIPE_W_DEF    = 80;
    localparam int BG_W          = 640;
    localparam int BG_BASE_DEF   = 0;
    localparam int PIPE_BASE_DEF = 307200;
    localparam int BIRD_BASE_DEF = 345600;
    localparam int ADDR_W_DEF    = 19;

    // Centre-to-corner offsets: bird is referenced by its centre row, pipe by its centre column
    localparam int BIRD_Y_OFS = 20;
    localparam int PIPE_X_OFS = 40;

    // Bird palette entries 1..6 are drawn; 0 and 7..15 let lower layers show through
    function automatic logic bird_opaque(input logic [3:0] idx);
        return (idx >= 4'd1) && (idx <= 4'd6);
    endfunction

endpackage

// File: rtl/sprite_addr_gen.sv
// Combinational sprite offset/address generator for the shared sprite ROM.
module sprite_addr_gen
    import fetch_pkg::*;
#(
    parameter int BIRD_X    = BIRD_X_DEF,
    parameter int BIRD_W    = BIRD_W_DEF,
    parameter int BIRD_H    = BIRD_H_DEF,
    parameter int PIPE_W    = PIPE_W_DEF,
    parameter int BG_BASE   = BG_BASE_DEF,
    parameter int PIPE_BASE = PIPE_BASE_DEF,
    parameter int BIRD_BASE = BIRD_BASE_DEF,
    parameter int ADDR_W    = ADDR_W_DEF
) (
    input  logic [9:0]        draw_x,
    input  logic [9:0]        draw_y,
    input  logic [9:0]        bird_y_pos,
    input  logic [9:0]        pipe_x_pos,
    output logic [ADDR_W-1:0] bg_addr,
    output logic [ADDR_W-1:0] pipe_addr,
    output logic [ADDR_W-1:0] bird_addr,
    output logic              bird_in_range,
    output logic              pipe_in_range
);

    logic [9:0] bird_x;
    logic [9:0] bird_y;
    logic [9:0] pipe_x;

    // Offsets wrap at 10 bits, so pixels left/above a sprite become large and fail the range test
    always_comb begin
        bird_x        = draw_x - 10'(BIRD_X);
        bird_y        = draw_y - bird_y_pos + 10'(BIRD_Y_OFS);
        pipe_x        = draw_x - pipe_x_pos + 10'(PIPE_X_OFS);
        bird_in_range = (bird_x < 10'(BIRD_W)) && (bird_y < 10'(BIRD_H));
        pipe_in_range = (pipe_x < 10'(PIPE_W));
        bird_addr     = ADDR_W'(BIRD_BASE) + ADDR_W'(bird_x) + ADDR_W'(bird_y) * ADDR_W'(BIRD_W);
        pipe_addr     = ADDR_W'(PIPE_BASE) + ADDR_W'(pipe_x) + ADDR_W'(draw_y) * ADDR_W'(PIPE_W);
        bg_addr       = ADDR_W'(BG_BASE) + ADDR_W'(draw_x) + ADDR_W'(draw_y) * ADDR_W'(BG_W);
    end

endmodule

// File: rtl/pixel_fetch_scheduler.sv
// Front-to-back layer fetch (bird, pipe, background) over one shared sprite ROM port.
module pixel_fetch_scheduler
    import fetch_pkg::*;
#(
    parameter int BIRD_X    = BIRD_X_DEF,
    parameter int BIRD_W    = BIRD_W_DEF,
    parameter int BIRD_H    = BIRD_H_DEF,
    parameter int PIPE_W    = PIPE_W_DEF,
    parameter int BG_BASE   = BG_BASE_DEF,
    parameter int PIPE_BASE = PIPE_BASE_DEF,
    parameter int BIRD_BASE = BIRD_BASE_DEF,
    parameter int ADDR_W    = ADDR_W_DEF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              pix_req,
    output logic              pix_ready,
    input  logic              is_bird,
    input  logic              is_pipe,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic [9:0]        Bird_Y_Pos_,
    input  logic [9:0]        Pipe_X_Pos_,
    output logic              rom_rd,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [3:0]        rom_data,
    output logic              pix_valid,
    output logic [1:0]        pix_layer,
    output logic [3:0]        pix_index
);

    state_t            state_q, state_d;
    layer_t            layer_q, layer_d;
    logic [9:0]        draw_x_q, draw_x_d;
    logic [9:0]        draw_y_q, draw_y_d;
    logic [9:0]        bird_y_q, bird_y_d;
    logic [9:0]        pipe_x_q, pipe_x_d;
    logic              is_bird_q, is_bird_d;
    logic              is_pipe_q, is_pipe_d;
    logic              rom_rd_q, rom_rd_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              pix_valid_q, pix_valid_d;
    logic [1:0]        pix_layer_q, pix_layer_d;
    logic [3:0]        pix_index_q, pix_index_d;

    logic              accept;
    logic [ADDR_W-1:0] bg_addr, pipe_addr, bird_addr;
    logic              bird_in_range, pipe_in_range;
    logic              bird_ok, pipe_ok;

    assign pix_ready = (state_q == IDLE) && !Reset;
    assign accept    = pix_req && pix_ready;

    // Latch the pixel on accept; the _d view lets the first address be formed in the accept cycle
    always_comb begin
        draw_x_d  = accept ? DrawX       : draw_x_q;
        draw_y_d  = accept ? DrawY       : draw_y_q;
        bird_y_d  = accept ? Bird_Y_Pos_ : bird_y_q;
        pipe_x_d  = accept ? Pipe_X_Pos_ : pipe_x_q;
        is_bird_d = accept ? is_bird     : is_bird_q;
        is_pipe_d = accept ? is_pipe     : is_pipe_q;
    end

    sprite_addr_gen #(
        .BIRD_X   (BIRD_X),
        .BIRD_W   (BIRD_W),
        .BIRD_H   (BIRD_H),
        .PIPE_W   (PIPE_W),
        .BG_BASE  (BG_BASE),
        .PIPE_BASE(PIPE_BASE),
        .BIRD_BASE(BIRD_BASE),
        .ADDR_W   (ADDR_W)
    ) u_addr_gen (
        .draw_x       (draw_x_d),
        .draw_y       (draw_y_d),
        .bird_y_pos   (bird_y_d),
        .pipe_x_pos   (pipe_x_d),
        .bg_addr      (bg_addr),
        .pipe_addr    (pipe_addr),
        .bird_addr    (bird_addr),
        .bird_in_range(bird_in_range),
        .pipe_in_range(pipe_in_range)
    );

    assign bird_ok = is_bird_d && bird_in_range;
    assign pipe_ok = is_pipe_d && pipe_in_range;

    // State and all registered outputs; reset abandons any fetch in flight
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            layer_q     <= BG;
            draw_x_q    <= '0;
            draw_y_q    <= '0;
            bird_y_q    <= '0;
            pipe_x_q    <= '0;
            is_bird_q   <= 1'b0;
            is_pipe_q   <= 1'b0;
            rom_rd_q    <= 1'b0;
            rom_addr_q  <= '0;
            pix_valid_q <= 1'b0;
            pix_layer_q <= '0;
            pix_index_q <= '0;
        end else begin
            state_q     <= state_d;
            layer_q     <= layer_d;
            draw_x_q    <= draw_x_d;
            draw_y_q    <= draw_y_d;
            bird_y_q    <= bird_y_d;
            pipe_x_q    <= pipe_x_d;
            is_bird_q   <= is_bird_d;
            is_pipe_q   <= is_pipe_d;
            rom_rd_q    <= rom_rd_d;
            rom_addr_q  <= rom_addr_d;
            pix_valid_q <= pix_valid_d;
            pix_layer_q <= pix_layer_d;
            pix_index_q <= pix_index_d;
        end
    end

    // Next state: pick the first eligible layer, fall through only past a transparent bird
    always_comb begin
        state_d = state_q;
        layer_d = layer_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = RD;
                    layer_d = bird_ok ? BIRD : (pipe_ok ? PIPE : BG);
                end
            end
            RD: state_d = CHK;
            CHK: begin
                if (layer_q == BIRD && !bird_opaque(rom_data)) begin
                    state_d = RD;
                    layer_d = pipe_ok ? PIPE : BG;
                end else begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with RD and DONE exactly
    always_comb begin
        rom_rd_d    = (state_d == RD);
        rom_addr_d  = rom_addr_q;
        pix_valid_d = (state_d == DONE);
        pix_layer_d = pix_layer_q;
        pix_index_d = pix_index_q;
        if (state_d == RD) begin
            case (layer_d)
                BIRD:    rom_addr_d = bird_addr;
                PIPE:    rom_addr_d = pipe_addr;
                default: rom_addr_d = bg_addr;
            endcase
        end
        if (state_q == CHK && state_d == DONE) begin
            pix_layer_d = layer_q;
            pix_index_d = rom_data;
        end
    end

    assign rom_rd    = rom_rd_q;
    assign rom_addr  = rom_addr_q;
    assign pix_valid = pix_valid_q;
    assign pix_layer = pix_layer_q;
    assign pix_index = pix_index_q;

endmodule
